// File: rtl/sram_1r1w_fifo_ctrl.sv
// sram_1r1w_fifo_ctrl: single-clock FIFO built on a 1R1W SRAM macro.
// Ports: clk/rst_n/flush, push_* (in), pop_* (out), level, sram port0 write / port1 read.
module sram_1r1w_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int OBUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int LW    = ADDR_WIDTH + 2;

  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);
  localparam logic [2:0]  OBUF_V  = 3'(OBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_mem_cnt;
  logic                  r_rd_s1;
  logic [1:0]            r_obuf_cnt;
  logic [LW-1:0]         r_level;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_obuf [2];

  logic [CW:0]   w_occ;
  logic          w_push_ready;
  logic          w_push_fire;
  logic          w_pop_valid;
  logic          w_pop_fire;
  logic [2:0]    w_obuf_occ;
  logic          w_rd_issue;
  logic          w_cap_hi;
  logic [CW-1:0] w_mem_cnt_nxt;
  logic          w_rd_s1_nxt;
  logic [1:0]    w_obuf_cnt_nxt;
  logic [LW-1:0] w_level_nxt;

  // A slot whose read is in flight stays counted until captured.
  assign w_occ = {1'b0, r_mem_cnt}
               + {{CW{1'b0}}, r_rd_s1};

  // r_run keeps push_ready low while reset is held.
  assign w_push_ready = r_run & ~flush
                      & (w_occ < DEPTH_V);
  assign w_push_fire  = push_valid & w_push_ready;

  assign w_pop_valid = (r_obuf_cnt != 2'd0);
  assign w_pop_fire  = w_pop_valid & pop_ready;

  // Buffer occupancy at end of cycle, counting
  // the word currently returning from the macro.
  assign w_obuf_occ = {1'b0, r_obuf_cnt}
                    + {2'b00, r_rd_s1}
                    - {2'b00, w_pop_fire};

  assign w_rd_issue = ~flush
                    & (r_mem_cnt != '0)
                    & (w_obuf_occ < OBUF_V);

  // Capture slot: first free entry after the pop.
  assign w_cap_hi = (r_obuf_cnt == 2'd2)
                  | ((r_obuf_cnt == 2'd1) & ~w_pop_fire);

  always_comb begin
    w_mem_cnt_nxt  = r_mem_cnt
                   + CW'(w_push_fire)
                   - CW'(w_rd_issue);
    w_rd_s1_nxt    = w_rd_issue;
    w_obuf_cnt_nxt = w_obuf_occ[1:0];
    if (flush) begin
      w_mem_cnt_nxt  = '0;
      w_rd_s1_nxt    = 1'b0;
      w_obuf_cnt_nxt = 2'd0;
    end
    w_level_nxt = LW'(w_mem_cnt_nxt)
                + LW'(w_rd_s1_nxt)
                + LW'(w_obuf_cnt_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_rd_s1    <= 1'b0;
      r_obuf_cnt <= 2'd0;
      r_level    <= '0;
      r_run      <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_mem_cnt  <= w_mem_cnt_nxt;
      r_rd_s1    <= w_rd_s1_nxt;
      r_obuf_cnt <= w_obuf_cnt_nxt;
      r_level    <= w_level_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_fire)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_issue)
          r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Data path: shift on pop, then land the
  // returning macro word behind what remains.
  always_ff @(posedge clk) begin
    if (w_pop_fire)
      r_obuf[0] <= r_obuf[1];
    if (r_rd_s1 && !flush)
      r_obuf[w_cap_hi] <= sram_dout1;
  end

  assign pop_valid  = w_pop_valid;
  assign pop_data   = r_obuf[0];
  assign push_ready = w_push_ready;
  assign level      = r_level;

  assign sram_csb0  = ~w_push_fire;
  assign sram_addr0 = r_wr_ptr;
  assign sram_din0  = push_data;
  assign sram_csb1  = ~w_rd_issue;
  assign sram_addr1 = r_rd_ptr;

  a_no_addr_clash: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(!sram_csb0 && !sram_csb1
      && sram_addr0 == sram_addr1));

endmodule

// File: tb/tb_sram_1r1w_fifo_ctrl.sv
// tb_sram_1r1w_fifo_ctrl: scoreboard bench with a behavioural macro model.
// Stimulus drives #1 after posedge; monitor and checks sample on negedge.
module tb_sram_1r1w_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_data = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_data;
  logic [8:0]  level;
  logic        sram_csb0;
  logic [6:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic        sram_csb1;
  logic [6:0]  sram_addr1;
  logic [31:0] sram_dout1 = '0;

  logic [31:0] mem [128];

  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  sram_1r1w_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .level      (level),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (push_valid && push_ready)
        sb.push_back(push_data);
      if (pop_valid && pop_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=%0h required=none",
                   pop_data);
        end else begin
          chk("pop_data", pop_data, sb.pop_front());
        end
        pops++;
      end
      if (flush) sb.delete();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, mp, stalls, gaps, n, p0;
    bit started, acc;

    // reset state, asserted asynchronously
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd0);
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_csb1", 32'(sram_csb1), 32'd1);
    repeat (2) @(posedge clk);
    chk("rst_hold_ready", 32'(push_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: single word latency
    cyc();
    push_valid = 1'b1;
    push_data  = 32'hA5A5_0001;
    pop_ready  = 1'b1;
    @(negedge clk);
    chk("t1_push_ready", 32'(push_ready), 32'd1);
    cyc();
    push_valid = 1'b0;
    @(negedge clk);
    chk("t1_pv_n1", 32'(pop_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_pv_n2", 32'(pop_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_pv_n3", 32'(pop_valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("t1_pv_after", 32'(pop_valid), 32'd0);
    chk("t1_level", 32'(level), 32'd0);

    // T2: 1000-word stream, one push and pop per cycle
    sent = 0; mp = 0; stalls = 0; gaps = 0;
    n = 0; started = 0;
    pop_ready = 1'b1;
    for (int c = 0; c < 1100 && mp < 1000; c++) begin
      cyc();
      push_valid = (sent < 1000);
      push_data  = 32'(sent);
      @(negedge clk);
      n++;
      if (push_valid && push_ready) sent++;
      else if (push_valid) stalls++;
      if (pop_valid) begin
        started = 1;
        mp++;
      end else if (started) begin
        gaps++;
      end
    end
    chk("t2_sent", 32'(sent), 32'd1000);
    chk("t2_popped", 32'(mp), 32'd1000);
    chk("t2_stalls", 32'(stalls), 32'd0);
    chk("t2_gaps", 32'(gaps), 32'd0);
    chk("t2_cycles", 32'(n), 32'd1003);
    cyc();
    push_valid = 1'b0;

    // T3: fill to capacity with no pops
    pop_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 300 && sent < 130; c++) begin
      cyc();
      push_valid = 1'b1;
      push_data  = 32'h300 + 32'(sent);
      @(negedge clk);
      if (push_ready) sent++;
    end
    chk("t3_sent", 32'(sent), 32'd130);
    cyc();
    push_data = 32'h400;
    @(negedge clk);
    chk("t3_level", 32'(level), 32'd130);
    chk("t3_full_ready", 32'(push_ready), 32'd0);
    chk("t3_pop_valid", 32'(pop_valid), 32'd1);

    // T4: pop while full; push refused then taken
    // once the refill read has landed
    cyc();
    pop_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_pop_cycle", 32'(push_ready), 32'd0);
    chk("t4_pop_valid", 32'(pop_valid), 32'd1);
    cyc();
    pop_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4 && !acc; k++) begin
      @(negedge clk);
      if (push_ready) acc = 1;
      else @(posedge clk);
    end
    chk("t4_push_accepted", 32'(acc), 32'd1);
    cyc();
    push_valid = 1'b0;
    @(negedge clk);
    chk("t4_level", 32'(level), 32'd130);

    // drain: order checked by the scoreboard
    p0 = pops;
    cyc();
    pop_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (level == 0 && !pop_valid) break;
    end
    chk("t4_drain_level", 32'(level), 32'd0);
    chk("t4_drain_count", 32'(pops - p0), 32'd130);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // T5: flush with a read in flight
    cyc();
    pop_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      if (c) cyc();
      push_valid = 1'b1;
      push_data  = 32'h500 + 32'(sent);
      @(negedge clk);
      if (push_ready) sent++;
    end
    cyc();
    push_valid = 1'b0;
    repeat (3) cyc();
    pop_ready = 1'b1;
    @(negedge clk);
    chk("t5_read_issued", 32'(sram_csb1), 32'd0);
    cyc();
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_ready", 32'(push_ready), 32'd0);
    chk("t5_flush_csb1", 32'(sram_csb1), 32'd1);
    cyc();
    flush = 1'b0;
    pop_ready = 1'b0;
    @(negedge clk);
    chk("t5_pv_after", 32'(pop_valid), 32'd0);
    chk("t5_level_after", 32'(level), 32'd0);
    p0 = pops;
    cyc();
    push_valid = 1'b1;
    push_data  = 32'h1234;
    pop_ready  = 1'b1;
    cyc();
    push_valid = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    chk("t5_pops", 32'(pops - p0), 32'd1);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // T6: async reset mid-stream
    cyc();
    pop_ready = 1'b1;
    push_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_data = 32'h600 + 32'(i);
      cyc();
    end
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_pop_valid", 32'(pop_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_push_ready", 32'(push_ready), 32'd0);
    chk("t6_csb0", 32'(sram_csb0), 32'd1);
    chk("t6_csb1", 32'(sram_csb1), 32'd1);
    push_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pops;
    cyc();
    push_valid = 1'b1;
    push_data  = 32'hBEEF;
    cyc();
    push_valid = 1'b0;
    repeat (6) cyc();
    @(negedge clk);
    chk("t6_pops", 32'(pops - p0), 32'd1);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_level_end", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
